// File: rtl/core_run_pkg.sv
// Shared definitions for the core run controller: FSM state encoding and
// core reset level helper, reused by RTL and benches.
package core_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  // Maps a logical "reset asserted" flag onto the physical core_rst level.
  function automatic logic rst_level(input int unsigned pol, input logic on);
    return (pol != 0) ? on : ~on;
  endfunction

endpackage

// File: rtl/halt_tracker.sv
// Per-hart halt latch: records the first halt strobe of a run and its code,
// and reports whether that hart has contributed a non-pass code.
module halt_tracker #(
  parameter int unsigned       CODE_W    = 32,
  parameter logic [CODE_W-1:0] PASS_CODE = CODE_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              halt_valid,
  input  logic [CODE_W-1:0] halt_code,
  output logic              halted,
  output logic              halted_nxt_c,
  output logic              bad_c
);

  logic [CODE_W-1:0] code;
  logic              take_c;

  // Only the first strobe in a run is captured; later ones are dropped.
  assign take_c = en && halt_valid && !halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
      code   <= '0;
    end else if (clear) begin
      halted <= 1'b0;
      code   <= '0;
    end else if (take_c) begin
      halted <= 1'b1;
      code   <= halt_code;
    end
  end

  // Look-ahead views so the controller can act on a halt in the same cycle.
  assign halted_nxt_c = halted || take_c;
  assign bad_c        = (halted && (code != PASS_CODE)) ||
                        (take_c && (halt_code != PASS_CODE));

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: holds the core(s) in reset, releases them, counts run
// cycles and reports pass/fail/timeout once every hart halts or budget expires.
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int unsigned       NUM_HARTS    = 1,
  parameter int unsigned       RESET_CYCLES = 4,
  parameter int unsigned       MAX_CYCLES   = 5000,
  parameter int unsigned       CNT_W        = 32,
  parameter int unsigned       CODE_W       = 32,
  parameter logic [CODE_W-1:0] PASS_CODE    = CODE_W'(1),
  parameter int unsigned       CORE_RST_POL = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_HARTS-1:0]        halt_valid,
  input  logic [NUM_HARTS*CODE_W-1:0] halt_code,
  output logic                        core_rst,
  output logic                        running,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic [NUM_HARTS-1:0]        halted,
  output logic [CNT_W-1:0]            cycle_count
);

  localparam int unsigned      HOLD_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);
  localparam logic              RST_ON    = rst_level(CORE_RST_POL, 1'b1);
  localparam logic              RST_OFF   = rst_level(CORE_RST_POL, 1'b0);

  run_state_t           state;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 run_c;
  logic                 clear_c;
  logic                 at_max_c;
  logic                 all_halted_c;
  logic                 any_bad_c;
  logic [NUM_HARTS-1:0] halted_nxt_c;
  logic [NUM_HARTS-1:0] bad_c;

  assign run_c        = (state == RUN);
  assign clear_c      = start && ((state == IDLE) || (state == DONE));
  assign at_max_c     = (cycle_count == CNT_MAX);
  assign all_halted_c = &halted_nxt_c;
  assign any_bad_c    = |bad_c;

  for (genvar i = 0; i < NUM_HARTS; i++) begin : g_hart
    halt_tracker #(
      .CODE_W    (CODE_W),
      .PASS_CODE (PASS_CODE)
    ) u_trk (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear_c),
      .en           (run_c),
      .halt_valid   (halt_valid[i]),
      .halt_code    (halt_code[i*CODE_W +: CODE_W]),
      .halted       (halted[i]),
      .halted_nxt_c (halted_nxt_c[i]),
      .bad_c        (bad_c[i])
    );
  end

  // Sequencer with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      core_rst    <= RST_ON;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            core_rst    <= RST_ON;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
          end
        end
        HOLD: begin
          // One clearing cycle plus RESET_CYCLES hold cycles before release.
          if (hold_cnt == HOLD_LAST) begin
            state    <= RUN;
            core_rst <= RST_OFF;
            running  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          // Count saturates at the budget so a timeout reports exactly MAX_CYCLES.
          if (!at_max_c) begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
          // A final halt landing on the budget cycle beats the timeout.
          if (all_halted_c || at_max_c) begin
            state    <= DONE;
            core_rst <= RST_ON;
            running  <= 1'b0;
            done     <= 1'b1;
            timeout  <= !all_halted_c;
            pass     <= all_halted_c && !any_bad_c;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: a 2-hart instance checked by a done-triggered
// scoreboard, plus a 1-hart inverted-polarity instance for reset timing.
module tb_core_run_ctrl;
  import core_run_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  halt_valid = '0;
  logic [63:0] halt_code = '0;

  logic        core_rst, running, done, pass, timeout;
  logic [1:0]  halted;
  logic [31:0] cycle_count;

  logic        core_rst_n, running_n, done_n, pass_n, timeout_n;
  logic [0:0]  halted_n;
  logic [31:0] cycle_count_n;
  logic [0:0]  halt_valid_n;
  logic [31:0] halt_code_n;

  assign halt_valid_n = halt_valid[0:0];
  assign halt_code_n  = halt_code[31:0];

  always #5 clk = ~clk;

  core_run_ctrl #(
    .NUM_HARTS(2), .RESET_CYCLES(4), .MAX_CYCLES(100), .CNT_W(32),
    .CODE_W(32), .PASS_CODE(32'd1), .CORE_RST_POL(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .halt_valid(halt_valid),
    .halt_code(halt_code), .core_rst(core_rst), .running(running),
    .done(done), .pass(pass), .timeout(timeout), .halted(halted),
    .cycle_count(cycle_count)
  );

  core_run_ctrl #(
    .NUM_HARTS(1), .RESET_CYCLES(4), .MAX_CYCLES(100), .CNT_W(32),
    .CODE_W(32), .PASS_CODE(32'd1), .CORE_RST_POL(0)
  ) dut_n (
    .clk(clk), .rst(rst), .start(start), .halt_valid(halt_valid_n),
    .halt_code(halt_code_n), .core_rst(core_rst_n), .running(running_n),
    .done(done_n), .pass(pass_n), .timeout(timeout_n), .halted(halted_n),
    .cycle_count(cycle_count_n)
  );

  typedef struct packed {
    logic        pass;
    logic        timeout;
    logic [31:0] count;
    logic [1:0]  halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic done_q   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: every rising done retires one expected run result.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        bound_fail("sb_unexpected_done");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pass", 64'(pass), 64'(e.pass));
        check("sb_timeout", 64'(timeout), 64'(e.timeout));
        check("sb_count", 64'(cycle_count), 64'(e.count));
        check("sb_halted", 64'(halted), 64'(e.halted));
      end
    end
    done_q = done;
  end

  task automatic wait_count(input int k);
    int n = 0;
    while (cycle_count != 32'(k) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) bound_fail("wait_count");
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) bound_fail("wait_done");
    @(negedge clk);
  endtask

  task automatic halt_at(input int k, input logic [1:0] v, input logic [31:0] c1, input logic [31:0] c0);
    wait_count(k);
    halt_valid = v;
    halt_code  = {c1, c0};
    @(negedge clk);
    halt_valid = '0;
  endtask

  // hold_action: 0 none, 1 start pulse during HOLD, 2 halt strobes during HOLD.
  task automatic start_run(input int hold_action);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clr_done", 64'(done), 64'd0);
    check("clr_pass", 64'(pass), 64'd0);
    check("clr_halted", 64'(halted), 64'd0);
    check("clr_count", 64'(cycle_count), 64'd0);
    check("hold_core_rst_n", 64'(core_rst_n), 64'd0);
    for (int e = 1; e <= 4; e++) begin
      if (e == 1 && hold_action == 1) start = 1'b1;
      if (e == 1 && hold_action == 2) begin
        halt_valid = 2'b11;
        halt_code  = {32'd3, 32'd3};
      end
      @(negedge clk);
      start      = 1'b0;
      halt_valid = '0;
      check("hold_core_rst", 64'(core_rst), 64'd1);
      check("hold_running", 64'(running), 64'd0);
    end
    @(negedge clk);
    check("rel_core_rst", 64'(core_rst), 64'd0);
    check("rel_core_rst_n", 64'(core_rst_n), 64'd1);
    check("rel_running", 64'(running), 64'd1);
    check("rel_running_n", 64'(running_n), 64'd1);
    check("rel_count", 64'(cycle_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_core_rst", 64'(core_rst), 64'd1);
    check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_count", 64'(cycle_count), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_core_rst", 64'(core_rst), 64'd1);

    // Run 1: both harts pass, stray start in HOLD and RUN, repeated strobe.
    exp_q.push_back('{pass: 1'b1, timeout: 1'b0, count: 32'd36, halted: 2'b11});
    start_run(1);
    wait_count(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_run", 64'(running), 64'd1);
    halt_at(20, 2'b01, 32'd0, 32'd1);
    check("halted_one", 64'(halted), 64'd1);
    halt_at(25, 2'b01, 32'd0, 32'd3);
    halt_at(35, 2'b10, 32'd1, 32'd0);
    wait_done();
    check("n1_count", 64'(cycle_count_n), 64'd21);
    check("n1_pass", 64'(pass_n), 64'd1);
    check("done_core_rst", 64'(core_rst), 64'd1);
    check("done_running", 64'(running), 64'd0);

    // Run 2: rerun from DONE, hart1 reports a failing code.
    exp_q.push_back('{pass: 1'b0, timeout: 1'b0, count: 32'd8, halted: 2'b11});
    start_run(0);
    halt_at(5, 2'b01, 32'd0, 32'd1);
    halt_at(7, 2'b10, 32'd3, 32'd0);
    wait_done();

    // Run 3: strobes during HOLD are ignored, then budget runs out.
    exp_q.push_back('{pass: 1'b0, timeout: 1'b1, count: 32'd100, halted: 2'b00});
    start_run(2);
    wait_done();
    check("n3_timeout", 64'(timeout_n), 64'd1);
    check("n3_count", 64'(cycle_count_n), 64'd100);

    // Run 4: last halt lands on the budget cycle and wins.
    exp_q.push_back('{pass: 1'b1, timeout: 1'b0, count: 32'd100, halted: 2'b11});
    start_run(0);
    halt_at(10, 2'b01, 32'd0, 32'd1);
    halt_at(100, 2'b10, 32'd1, 32'd0);
    wait_done();

    // Run 5: asynchronous reset mid-run, then no restart without start.
    start_run(0);
    halt_at(10, 2'b01, 32'd0, 32'd1);
    wait_count(50);
    check("pre_rst_halted", 64'(halted), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_core_rst", 64'(core_rst), 64'd1);
    check("arst_core_rst_n", 64'(core_rst_n), 64'd0);
    check("arst_running", 64'(running), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_pass", 64'(pass), 64'd0);
    check("arst_timeout", 64'(timeout), 64'd0);
    check("arst_halted", 64'(halted), 64'd0);
    check("arst_count", 64'(cycle_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_core_rst", 64'(core_rst), 64'd1);
    check("post_rst_running", 64'(running), 64'd0);
    check("post_rst_count", 64'(cycle_count), 64'd0);

    // Run 6: both harts halt in the very first RUN cycle.
    exp_q.push_back('{pass: 1'b1, timeout: 1'b0, count: 32'd1, halted: 2'b11});
    start_run(0);
    halt_at(0, 2'b11, 32'd1, 32'd1);
    wait_done();

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and reset, rst; reset is asynchronous and active-high.
REQ-002 Parameter NUM_HARTS, default 1: number of cores monitored, range 1..8.
REQ-003 Parameter RESET_CYCLES, default 4: core reset hold length in clk cycles, minimum 1.
REQ-004 Parameter MAX_CYCLES, default 5000: run-cycle budget before timeout, 1..2^CNT_W-1.
REQ-005 Parameter CNT_W, default 32: cycle counter width.
REQ-006 Parameter CODE_W, default 32: halt code width per hart.
REQ-007 Parameter PASS_CODE, default 1: halt code meaning pass.
REQ-008 Parameter CORE_RST_POL, default 1: core_rst asserted level (1 active-high, 0 active-low).
REQ-009 Ports SHALL be:
 clk  in  1  clock
 rst  in  1  async active-high reset
 start  in  1  launch a run, single-cycle pulse
 halt_valid  in  NUM_HARTS  per-hart halt strobe (tohost write)
 halt_code  in  NUM_HARTS*CODE_W  per-hart code, hart i at bits [i*CODE_W +: CODE_W]
 core_rst  out  1  reset to core(s), polarity per CORE_RST_POL
 running  out  1  core released and counting
 done  out  1  run finished
 pass  out  1  all harts halted with PASS_CODE, no timeout
 timeout  out  1  budget exhausted
 halted  out  NUM_HARTS  per-hart halted flags
 cycle_count  out  CNT_W  RUN cycles elapsed

Function
REQ-010 FSM states SHALL be IDLE, HOLD, RUN, DONE; core_rst asserted in IDLE, HOLD, DONE, deasserted only in RUN.
REQ-011 IDLE: start=1 SHALL move to HOLD and clear hold counter, cycle_count, halted, captured codes, done, pass, timeout.
REQ-012 HOLD SHALL last exactly RESET_CYCLES cycles, then move to RUN; start pulse at edge N gives core_rst deasserted after edge N+1+RESET_CYCLES.
REQ-013 RUN: running=1; cycle_count SHALL increment by 1 per RUN cycle, never wrapping.
REQ-014 In RUN, halt_valid[i] with halted[i]=0 SHALL set halted[i] and capture halt_code[i]; later strobes from that hart SHALL be ignored.
REQ-015 Any captured code != PASS_CODE SHALL set a sticky fail flag.
REQ-016 When all halted bits are 1 (including bits set that cycle) the FSM SHALL enter DONE next cycle.
REQ-017 When cycle_count equals MAX_CYCLES with any hart unhalted, FSM SHALL enter DONE with timeout=1.
REQ-018 If the last halt and the timeout condition occur in the same cycle, halt SHALL win: timeout=0.
REQ-019 DONE: done=1, running=0, cycle_count and halted frozen, pass = (no fail) AND (timeout=0).
REQ-020 start in HOLD or RUN SHALL be ignored; start in DONE SHALL behave as in IDLE (rerun).
REQ-021 halt_valid outside RUN SHALL be ignored.
REQ-022 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-023 rst SHALL force IDLE, core_rst asserted, running=0, done=0, pass=0, timeout=0, halted=0, cycle_count=0, regardless of state.
REQ-024 rst asserted mid-RUN SHALL reassert core_rst asynchronously; after release a new start is required.

Structure
REQ-025 State encodings (IDLE=0, HOLD=1, RUN=2, DONE=3) SHALL live in a shared package/include core_run_pkg, reused by benches.
REQ-026 Per-hart halt latch and code capture SHALL be one sub-module, halt_tracker, instantiated NUM_HARTS times.

Verification
REQ-027 NUM_HARTS=1, RESET_CYCLES=4: start at cycle 10 -> core_rst asserted through cycle 14, deasserted at cycle 15, running=1.
REQ-028 NUM_HARTS=2, PASS_CODE=1: hart0 halts code 1 at run cycle 20, hart1 code 1 at 35 -> done=1, pass=1, cycle_count=36, timeout=0.
REQ-029 NUM_HARTS=2: hart1 halts code 3 -> after both halt, done=1, pass=0, timeout=0.
REQ-030 MAX_CYCLES=100, no halt -> done=1, timeout=1, pass=0, cycle_count=100; same-cycle halt at count 100 -> timeout=0, pass=1.
REQ-031 rst pulsed at run cycle 50 -> all outputs at reset values immediately; repeated halt_valid on a halted hart leaves captured code unchanged.
REQ-032 start in DONE -> rerun with cleared flags, identical timing to REQ-027; CORE_RST_POL=0 -> core_rst levels inverted.
